fib_main_controller: RTL
========================

# fib_main_controller

Main sequencer for the recursive Fibonacci engine. It walks the fib(n) call tree using the stack as explicit frame storage. It issues one-cycle pushSig/popSig requests to the stack controller and paces them on its readySig. It also drives load, decrement and add strobes into the N / RES / FLAG / RV datapath registers, tracks frame depth, and reports done (RV = fib(n)) or stack overflow.

## Interface
- MAX_FRAMES, 8, stack capacity in frames; one frame is N, RES, FLAG (3 entries).
- DW, 4, depth counter width; must satisfy 2^DW > MAX_FRAMES.
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a computation; sampled only in IDLE.
- nLt2  in  1  datapath flag: N < 2.
- flag  in  1  datapath FLAG register (0: first child pending, 1: second child pending).
- readySig  in  1  stack controller idle/confirm indication.
- pushSig, popSig  out  1  one-cycle stack requests.
- ldN  out  1  N <= external n.
- decN1, decN2  out  1  N <= N-1 / N <= N-2.
- ldRvN  out  1  RV <= N.
- ldResRv  out  1  RES <= RV.
- addRv  out  1  RV <= RES + RV.
- setFlag, clrFlag  out  1  FLAG <= 1 / 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; RV holds fib(n).
- err  out  1  overflow sticky flag (see Configuration).

## Operation
- Reset: state IDLE, depth = 0, all outputs 0.
- Internal depth counter: DW bits, counts frames currently on the stack.
- IDLE: on start, assert ldN and clrFlag, clear depth, go to CHECK.
- CHECK: if nLt2, assert ldRvN and go to RET. Otherwise assert clrFlag and go to CALL0.
- CALL0 / CALL1: hold until readySig = 1. In that cycle assert pushSig, increment depth, and go to CALL0W / CALL1W.
- CALL0W / CALL1W: stay while readySig = 0 and exit on the first readySig = 1.
  - CALL0W exit asserts decN1; CALL1W exit asserts decN2.
  - Both go to CHECK.
- RET: if depth = 0, go to DONE. Otherwise go to POP0.
- POP0: hold until readySig = 1. In that cycle assert popSig, decrement depth, and go to POPW.
- POPW: stay while readySig = 0. On readySig = 1, go to DISPATCH.
- DISPATCH: reads the restored FLAG.
  - flag = 0: assert ldResRv and setFlag, go to CALL1.
  - flag = 1: assert addRv, go to RET.
- DONE: done = 1 for one cycle, then IDLE.
- Datapath registers (N, RES, FLAG) must not change while a push or pop is in flight. No strobe is asserted in the *W states except on their exit cycle.
- start outside IDLE is ignored. Depth never underflows, because RET checks depth before popping.

## Timing
- A command is issued only in a cycle where readySig = 1 and the stack controller is in START.
- Each wait state exits on the stack's CONFIRM cycle, 4 cycles after issue. The following non-issuing cycle (CHECK or DISPATCH) covers the stack's return to START, so no request ever lands on CONFIRM.
- Push or pop round trip: 5 cycles, issue through wait-state exit.
- n < 2: start sampled in cycle t (IDLE), CHECK at t+1, RET at t+2, done at t+3.
- Each internal call-tree node costs 2 pushes plus 2 pops.
- rst mid-operation (any state, including a wait state): IDLE on the next edge, outputs 0, depth 0. The stack controller is reset alongside by the system.

## Configuration
- FIB_CTRL_OVF_CHECK_EN defined:
  - In CALL0 or CALL1 with depth = MAX_FRAMES, no push is issued; go to ERR.
  - ERR: err = 1, busy = 1, done never asserted; only rst exits.
- Not defined: no capacity check, err tied to 0, ERR state absent. Depth beyond MAX_FRAMES wraps modulo 2^DW, and correct results are the integrator's responsibility.

## Test plan
All scenarios use the stack controller plus a behavioural datapath and stack model.
- n=0, start pulse at cycle t -> done at t+3, RV=0, zero pushes/pops.
- n=1 -> done at t+3, RV=1.
- n=5 -> RV=5, exactly 14 pushSig and 14 popSig pulses, maximum depth 4, depth 0 at done, pushSig/popSig never asserted while readySig=0.
- n=9, MAX_FRAMES=8 -> RV=34, maximum depth 8, err=0.
- n=10, MAX_FRAMES=8, macro defined -> err=1 when the 9th frame is attempted, no 9th push, done never pulses. Macro undefined with MAX_FRAMES=16 -> RV=55.
- rst asserted for one cycle during POPW of an n=6 run -> IDLE next cycle, all outputs 0. A fresh start with n=6 then gives RV=8.

Source files
------------

// File: rtl/fib_main_controller.sv
// fib_main_controller: sequencer walking the fib(n) call tree with the stack as frame storage.
// Define FIB_CTRL_OVF_CHECK_EN to stop in a sticky ERR state instead of pushing past MAX_FRAMES.
module fib_main_controller #(
    parameter int MAX_FRAMES = 8,
    parameter int DW = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic nLt2,
    input  logic flag,
    input  logic readySig,
    output logic pushSig,
    output logic popSig,
    output logic ldN,
    output logic decN1,
    output logic decN2,
    output logic ldRvN,
    output logic ldResRv,
    output logic addRv,
    output logic setFlag,
    output logic clrFlag,
    output logic busy,
    output logic done,
    output logic err
);
    typedef enum logic [3:0] {
        IDLE, CHECK, CALL0, CALL0W, CALL1, CALL1W, RET, POP0, POPW, DISPATCH, DONE
`ifdef FIB_CTRL_OVF_CHECK_EN
        , ERR
`endif
    } state_t;

    state_t state, nextState;
    logic [DW-1:0] depth, nextDepth;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            depth <= '0;
        end else begin
            state <= nextState;
            depth <= nextDepth;
        end
    end

    always_comb begin
        nextState = state;
        nextDepth = depth;
        pushSig = 1'b0;
        popSig = 1'b0;
        ldN = 1'b0;
        decN1 = 1'b0;
        decN2 = 1'b0;
        ldRvN = 1'b0;
        ldResRv = 1'b0;
        addRv = 1'b0;
        setFlag = 1'b0;
        clrFlag = 1'b0;
        done = 1'b0;
        err = 1'b0;
        busy = state != IDLE;
        case (state)
            IDLE: if (start) begin
                ldN = 1'b1;
                clrFlag = 1'b1;
                nextDepth = '0;
                nextState = CHECK;
            end
            CHECK: begin
                ldRvN = nLt2;
                clrFlag = !nLt2;
                nextState = nLt2 ? RET : CALL0;
            end
            CALL0, CALL1:
`ifdef FIB_CTRL_OVF_CHECK_EN
                if (depth == DW'(MAX_FRAMES)) nextState = ERR;
                else
`endif
                if (readySig) begin
                    pushSig = 1'b1;
                    nextDepth = depth + 1'b1;
                    nextState = state == CALL0 ? CALL0W : CALL1W;
                end
            // Wait states only strobe the datapath on the stack's confirm cycle
            CALL0W: if (readySig) begin
                decN1 = 1'b1;
                nextState = CHECK;
            end
            CALL1W: if (readySig) begin
                decN2 = 1'b1;
                nextState = CHECK;
            end
            RET: nextState = depth == '0 ? DONE : POP0;
            POP0: if (readySig) begin
                popSig = 1'b1;
                nextDepth = depth - 1'b1;
                nextState = POPW;
            end
            POPW: if (readySig) nextState = DISPATCH;
            DISPATCH: begin
                addRv = flag;
                ldResRv = !flag;
                setFlag = !flag;
                nextState = flag ? RET : CALL1;
            end
            DONE: begin
                done = 1'b1;
                nextState = IDLE;
            end
`ifdef FIB_CTRL_OVF_CHECK_EN
            ERR: err = 1'b1;
`endif
            default: nextState = IDLE;
        endcase
    end
endmodule
